oc_bus_arbiter: RTL and testbench

OC_BUS_ARBITER -- requirements
Module: oc_bus_arbiter

---
 rtl/oc_bus_arbiter_pkg.sv | 15 +
 rtl/oc_bus_arbiter_if.sv | 27 ++
 rtl/oc_bus_arbiter_rr_pick.sv | 38 +++
 rtl/oc_bus_arbiter.sv | 129 ++++++++++++
 tb/tb_oc_bus_arbiter.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/oc_bus_arbiter_pkg.sv
// Shared types and default constants for the open-collector bus arbiter.
// The OC_ARB_TIMEOUT_EN macro enables the MAX_HOLD ownership limit.
package oc_pkg;

    localparam int NREQ_DEF     = 3;
    localparam int TURN_CYC_DEF = 1;
    localparam int MAX_HOLD_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } state_t;

endpackage

// File: rtl/oc_bus_arbiter_if.sv
// Requester-side bundle of the open-collector arbiter: requests and data bits in,
// ownership and line-drive status out.
interface oc_bus_arbiter_if
    import oc_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
) ();

    logic [NREQ-1:0]         req;
    logic [NREQ-1:0]         tx_bit;
    logic [NREQ-1:0]         grant;
    logic [$clog2(NREQ)-1:0] owner_id;
    logic                    pull_low;
    logic                    busy;
    logic                    timeout;

    modport master (
        output req, tx_bit,
        input  grant, owner_id, pull_low, busy, timeout
    );

    modport slave (
        input  req, tx_bit,
        output grant, owner_id, pull_low, busy, timeout
    );

endinterface

// File: rtl/oc_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set request after last_i (with wrap)
// wins, so the previous owner always ranks last.
module rr_pick
    import oc_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
) (
    input  logic [NREQ-1:0]         req_i,
    input  logic [$clog2(NREQ)-1:0] last_i,
    output logic [NREQ-1:0]         grant_o,
    output logic [$clog2(NREQ)-1:0] idx_o,
    output logic                    valid_o
);

    localparam int IDXW = $clog2(NREQ);

    logic [IDXW-1:0] pos_s;
    logic            hit_s;
    logic            found_s;

    // Walk the ring starting just past the last owner and keep the first hit.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        pos_s   = '0;
        hit_s   = 1'b0;
        found_s = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            pos_s          = IDXW'((int'(last_i) + k) % NREQ);
            hit_s          = !found_s && req_i[pos_s];
            grant_o[pos_s] = grant_o[pos_s] | hit_s;
            idx_o          = hit_s ? pos_s : idx_o;
            found_s        = found_s | hit_s;
        end
        valid_o = found_s;
    end

endmodule

// File: rtl/oc_bus_arbiter.sv
// Open-collector bus arbiter: round-robin ownership with a fixed released-bus
// turnaround; OC_ARB_TIMEOUT_EN adds a MAX_HOLD revocation with a timeout pulse.
module oc_bus_arbiter
    import oc_pkg::*;
#(
    parameter int NREQ     = NREQ_DEF,
    parameter int TURN_CYC = TURN_CYC_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input logic             clk,
    input logic             rst,
    oc_bus_arbiter_if.slave bus
);

    localparam int IDXW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || TURN_CYC < 1 || TURN_CYC > 7 ||
        MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_param_err
        $error("oc_bus_arbiter: parameter out of range");
    end

    state_t          state_q;
    logic [NREQ-1:0] grant_q;
    logic [IDXW-1:0] owner_q;
    logic [IDXW-1:0] last_q;
    logic            busy_q;
    logic [2:0]      turn_q;
    logic            owner_req_s;
    logic            revoke_s;
    logic [NREQ-1:0] win_s;
    logic [IDXW-1:0] win_idx_s;
    logic            win_vld_s;

    rr_pick #(.NREQ(NREQ)) u_rr_pick (
        .req_i   (bus.req),
        .last_i  (last_q),
        .grant_o (win_s),
        .idx_o   (win_idx_s),
        .valid_o (win_vld_s)
    );

    assign owner_req_s = bus.req[owner_q];

`ifdef OC_ARB_TIMEOUT_EN
    logic [7:0] hold_q;
    logic       timeout_q;
    assign revoke_s    = (state_q == OWN) && owner_req_s && (hold_q == 8'(MAX_HOLD));
    assign bus.timeout = timeout_q;
`else
    assign revoke_s    = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    // Arbitration FSM; grant, owner_id and busy all come straight from these registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            last_q  <= IDXW'(NREQ - 1);
            busy_q  <= 1'b0;
            turn_q  <= 3'd0;
`ifdef OC_ARB_TIMEOUT_EN
            hold_q    <= 8'd0;
            timeout_q <= 1'b0;
`endif
        end else begin
`ifdef OC_ARB_TIMEOUT_EN
            timeout_q <= revoke_s;
            hold_q    <= 8'd0;
`endif
            case (state_q)
                IDLE: begin
                    if (win_vld_s) begin
                        state_q <= OWN;
                        grant_q <= win_s;
                        owner_q <= win_idx_s;
                        last_q  <= win_idx_s;
                        busy_q  <= 1'b1;
`ifdef OC_ARB_TIMEOUT_EN
                        hold_q  <= 8'd1;
`endif
                    end
                end
                OWN: begin
                    if (!owner_req_s || revoke_s) begin
                        state_q <= TURN;
                        grant_q <= '0;
                        owner_q <= '0;
                        turn_q  <= 3'd0;
                    end else begin
`ifdef OC_ARB_TIMEOUT_EN
                        hold_q  <= hold_q + 8'd1;
`endif
                    end
                end
                TURN: begin
                    if (turn_q != 3'(TURN_CYC - 1)) begin
                        turn_q <= turn_q + 3'd1;
                    end else if (win_vld_s) begin
                        state_q <= OWN;
                        grant_q <= win_s;
                        owner_q <= win_idx_s;
                        last_q  <= win_idx_s;
`ifdef OC_ARB_TIMEOUT_EN
                        hold_q  <= 8'd1;
`endif
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                    owner_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grant    = grant_q;
    assign bus.owner_id = owner_q;
    assign bus.busy     = busy_q;
    // Only the owner may pull the line, so a zero grant can never drive it.
    assign bus.pull_low = |(grant_q & ~bus.tx_bit);

endmodule

// File: tb/tb_oc_bus_arbiter.sv
// Self-checking bench for oc_bus_arbiter: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural ownership model.
module tb_oc_bus_arbiter;

    localparam int N    = 3;
    localparam int TURN = 1;
    localparam int HOLD = 4;
`ifdef OC_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   chk_en = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    // Model: current owner (-1 = nobody), remaining released cycles, cycles owned, last winner.
    int m_owner;
    int m_turn_left;
    int m_hold;
    int m_last;
    bit m_timeout;

    oc_bus_arbiter_if #(.NREQ(N)) bus ();

    oc_bus_arbiter #(.NREQ(N), .TURN_CYC(TURN), .MAX_HOLD(HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #20 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner     = -1;
        m_turn_left = 0;
        m_hold      = 0;
        m_last      = N - 1;
        m_timeout   = 1'b0;
    endtask

    task automatic model_pick(input logic [N-1:0] r);
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (m_last + k) % N;
            if (r[idx]) begin
                m_owner = idx;
                m_last  = idx;
                m_hold  = 0;
                break;
            end
        end
    endtask

    task automatic model_step();
        logic [N-1:0] r;
        r = bus.req;
        m_timeout = 1'b0;
        if (rst) begin
            model_reset();
        end else if (m_owner >= 0) begin
            m_hold++;
            if (!r[m_owner]) begin
                m_owner     = -1;
                m_turn_left = TURN;
            end else if (TO_EN && m_hold >= HOLD) begin
                m_timeout   = 1'b1;
                m_owner     = -1;
                m_turn_left = TURN;
            end
        end else begin
            if (m_turn_left > 0) m_turn_left--;
            if (m_turn_left == 0 && r != '0) model_pick(r);
        end
    endtask

    task automatic tick(input logic [N-1:0] r, input logic [N-1:0] t);
        bus.req    = r;
        bus.tx_bit = t;
        @(posedge clk);
        model_step();
        #2;
    endtask

    // Per-cycle comparison of every output against the model, away from the active edge.
    always @(negedge clk) begin : cmp
        int eg;
        int eid;
        int ep;
        if (chk_en) begin
            eg  = (m_owner >= 0) ? (1 << m_owner) : 0;
            eid = (m_owner >= 0) ? m_owner : 0;
            ep  = 0;
            if (m_owner >= 0) ep = (bus.tx_bit[m_owner] == 1'b0) ? 1 : 0;
            chk("grant",    int'(bus.grant),    eg);
            chk("owner_id", int'(bus.owner_id), eid);
            chk("busy",     int'(bus.busy),     (m_owner >= 0 || m_turn_left > 0) ? 1 : 0);
            chk("pull_low", int'(bus.pull_low), ep);
            chk("timeout",  int'(bus.timeout),  int'(m_timeout));
        end
    end

    initial begin
        bus.req    = '0;
        bus.tx_bit = '1;
        model_reset();
        #1;
        chk("rst_grant",   int'(bus.grant),    0);
        chk("rst_owner",   int'(bus.owner_id), 0);
        chk("rst_busy",    int'(bus.busy),     0);
        chk("rst_timeout", int'(bus.timeout),  0);
        chk("rst_pull",    int'(bus.pull_low), 0);
        tick('0, '1);
        tick('0, '1);
        rst    = 1'b0;
        chk_en = 1'b1;

        // First grant after reset goes to requester 0 one edge after req is seen.
        tick(3'b001, 3'b000);
        chk("first_grant", int'(bus.grant),    1);
        chk("first_pull",  int'(bus.pull_low), 1);
        chk("first_busy",  int'(bus.busy),     1);

        // All requesting, each owner releasing in turn.
        tick(3'b111, 3'b000); chk("rr_hold0", int'(bus.grant), 1);
        tick(3'b110, 3'b000); chk("rr_turn0", int'(bus.grant), 0);
        tick(3'b111, 3'b000); chk("rr_g1",    int'(bus.grant), 2);
        chk("rr_id1", int'(bus.owner_id), 1);
        tick(3'b101, 3'b000); chk("rr_turn1", int'(bus.grant), 0);
        tick(3'b111, 3'b000); chk("rr_g2",    int'(bus.grant), 4);
        chk("rr_id2", int'(bus.owner_id), 2);
        tick(3'b011, 3'b000); chk("rr_turn2", int'(bus.grant), 0);
        tick(3'b111, 3'b000); chk("rr_g0",    int'(bus.grant), 1);

        // Owner 1 holds while requester 0 waits; no preemption.
        tick(3'b010, 3'b111); chk("np_turn", int'(bus.grant), 0);
        tick(3'b011, 3'b111); chk("np_g1",   int'(bus.grant), 2);
        tick(3'b011, 3'b111); chk("np_hold", int'(bus.grant), 2);
        tick(3'b011, 3'b111); chk("np_hold", int'(bus.grant), 2);
        tick(3'b001, 3'b111); chk("np_rel",  int'(bus.grant), 0);
        tick(3'b001, 3'b111); chk("np_g0",   int'(bus.grant), 1);
        tick(3'b000, 3'b111);
        tick(3'b000, 3'b111);
        chk("idle_busy", int'(bus.busy), 0);

        // Live tx_bit sweep under each owner, and with the bus released.
        for (int i = 0; i < N; i++) begin
            tick(N'(1 << i), 3'b111);
            chk("sweep_grant", int'(bus.grant), 1 << i);
            for (int t = 0; t < 8; t++) begin
                bus.tx_bit = 3'(t);
                #1;
                chk("sweep_pull", int'(bus.pull_low), ((t >> i) & 1) == 0 ? 1 : 0);
            end
            tick(3'b000, 3'b111);
            for (int t = 0; t < 8; t++) begin
                bus.tx_bit = 3'(t);
                #1;
                chk("sweep_pull_nogrant", int'(bus.pull_low), 0);
            end
            tick(3'b000, 3'b111);
        end

        // Requester 2 holds continuously: revoked after HOLD cycles only with the timeout build.
        tick(3'b100, 3'b000);
        chk("hold_g", int'(bus.grant), 4);
        for (int c = 0; c < HOLD - 1; c++) begin
            tick(3'b100, 3'b000);
            chk("hold_keep", int'(bus.grant), 4);
        end
        tick(3'b100, 3'b000);
`ifdef OC_ARB_TIMEOUT_EN
        chk("to_drop",  int'(bus.grant),   0);
        chk("to_pulse", int'(bus.timeout), 1);
        tick(3'b100, 3'b000);
        chk("to_regrant", int'(bus.grant),   4);
        chk("to_once",    int'(bus.timeout), 0);
`else
        chk("no_to_keep",  int'(bus.grant),   4);
        chk("no_to_pulse", int'(bus.timeout), 0);
`endif
        tick(3'b000, 3'b111);
        tick(3'b000, 3'b111);

        // Asynchronous reset while owner 1 pulls the line low.
        tick(3'b010, 3'b000);
        chk("ar_grant", int'(bus.grant),    2);
        chk("ar_pull",  int'(bus.pull_low), 1);
        rst = 1'b1;
        model_reset();
        #1;
        chk("ar_pull0",  int'(bus.pull_low), 0);
        chk("ar_grant0", int'(bus.grant),    0);
        chk("ar_busy0",  int'(bus.busy),     0);
        tick(3'b010, 3'b000);
        rst = 1'b0;
        tick(3'b011, 3'b000);
        chk("ar_first0", int'(bus.grant), 1);

        // Randomized traffic with occasional reset pulses.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(199) == 0) begin
                rst = 1'b1;
                model_reset();
            end else begin
                rst = 1'b0;
            end
            tick(N'($urandom | $urandom), N'($urandom));
        end
        rst = 1'b0;
        tick('0, '1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
